// File: rtl/i2c_slave_frontend.sv
// ---------------------------------------------------------------------------
// i2c_slave_frontend
//
// Bus-side front end of the I2C SRAM slave. It synchronises the raw SCL/SDA
// pad signals, detects START / STOP / repeated START, deserialises the
// address and data bytes, ACKs its own 7-bit device address and serialises
// read data handed over by the memory-access controller through a byte-level
// handshake. The controller never samples SDA itself.
//
// Optional build macro: I2C_GLITCH_FILTER_EN
//   defined   : a 3-sample stability filter follows each synchroniser, so
//               pulses of 2 clocks or less never reach edge detection; every
//               edge-derived latency grows by 2 clock cycles.
//   undefined : synchroniser outputs feed edge detection directly.
//
// Parameters:
//   DEVICE_ADDR   7-bit slave address that is ACKed
//   SYNC_STAGES   flip-flop depth of the SCL/SDA synchronisers (>= 2)
//
// Ports:
//   clock          system clock, at least 16x the SCL frequency
//   reset          asynchronous, active-high reset
//   scl_in         raw SCL from the pad
//   sda_in         raw SDA from the pad
//   sda_drive_low  1 = pull SDA low (open-drain enable), 0 = release
//   start_pulse    one-cycle pulse on START or repeated START
//   stop_pulse     one-cycle pulse on STOP
//   addr_match     high from the address ACK until STOP or the next START
//   rw_bit         R/W bit of the address byte (1 = master read)
//   rx_byte        last received data byte
//   rx_valid       one-cycle pulse: rx_byte is valid
//   rx_first       qualifies rx_valid: first byte after the address
//   tx_data        byte to send on a master read
//   tx_req         one-cycle pulse: tx_data is sampled in this cycle
//   busy           high between START and STOP
// ---------------------------------------------------------------------------
module i2c_slave_frontend #(
  parameter logic [6:0] DEVICE_ADDR = 7'h01,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       addr_match,
  output logic       rw_bit,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_RX        = 3'd3;
  localparam logic [2:0] ST_RX_ACK    = 3'd4;
  localparam logic [2:0] ST_TX        = 3'd5;
  localparam logic [2:0] ST_TX_ACK    = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  // -------------------------------------------------------------------------
  // Line conditioning: bit 0 = SCL, bit 1 = SDA. Each line gets its own
  // synchroniser (idle-high reset value) and, optionally, a stability filter.
  // -------------------------------------------------------------------------
  logic [1:0] line_raw;
  logic [1:0] line_s;

  assign line_raw = {sda_in, scl_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync_reg <= '1;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_raw[gi]};
        end
      end

`ifdef I2C_GLITCH_FILTER_EN
      // The filtered level follows the synchroniser only once the current
      // sample and the two previous ones agree. The output is taken from the
      // combinational next value so the added delay is exactly 2 cycles.
      logic [1:0] hist_reg;
      logic       filt_reg;
      logic       filt_next;

      always_comb begin
        filt_next = filt_reg;
        if ((sync_reg[SYNC_STAGES-1] == hist_reg[0]) && (hist_reg[0] == hist_reg[1])) begin
          filt_next = sync_reg[SYNC_STAGES-1];
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          hist_reg <= 2'b11;
          filt_reg <= 1'b1;
        end else begin
          hist_reg <= {hist_reg[0], sync_reg[SYNC_STAGES-1]};
          filt_reg <= filt_next;
        end
      end

      assign line_s[gi] = filt_next;
`else
      assign line_s[gi] = sync_reg[SYNC_STAGES-1];
`endif
    end
  endgenerate

  logic scl_s;
  logic sda_s;
  logic scl_d_reg;
  logic sda_d_reg;

  assign scl_s = line_s[0];
  assign sda_s = line_s[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_d_reg <= 1'b1;
      sda_d_reg <= 1'b1;
    end else begin
      scl_d_reg <= scl_s;
      sda_d_reg <= sda_s;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic sda_rise;
  logic sda_fall;
  logic start_cond;
  logic stop_cond;

  assign scl_rise   =  scl_s & ~scl_d_reg;
  assign scl_fall   = ~scl_s &  scl_d_reg;
  assign sda_rise   =  sda_s & ~sda_d_reg;
  assign sda_fall   = ~sda_s &  sda_d_reg;
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;

  // -------------------------------------------------------------------------
  // Protocol state machine
  // -------------------------------------------------------------------------
  logic [2:0] state_reg,      state_next;
  logic [7:0] shift_reg,      shift_next;
  logic [3:0] bit_cnt_reg,    bit_cnt_next;
  logic       ack_phase_reg,  ack_phase_next;   // ACK states: 1 = ACK driven / master ACK seen
  logic       first_pend_reg, first_pend_next;  // next received byte is the word address
  logic       drive_reg,      drive_next;
  logic       match_reg,      match_next;
  logic       rw_reg,         rw_next;
  logic [7:0] rx_byte_reg,    rx_byte_next;
  logic       rx_valid_reg,   rx_valid_next;
  logic       rx_first_reg,   rx_first_next;
  logic       tx_req_reg,     tx_req_next;
  logic       start_reg,      start_next;
  logic       stop_reg,       stop_next;
  logic       busy_reg,       busy_next;
  logic [3:0] bit_cnt_inc;

  assign bit_cnt_inc = bit_cnt_reg + 4'd1;

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    ack_phase_next  = ack_phase_reg;
    first_pend_next = first_pend_reg;
    drive_next      = drive_reg;
    match_next      = match_reg;
    rw_next         = rw_reg;
    rx_byte_next    = rx_byte_reg;
    busy_next       = busy_reg;
    rx_valid_next   = 1'b0;
    rx_first_next   = 1'b0;
    tx_req_next     = 1'b0;
    start_next      = 1'b0;
    stop_next       = 1'b0;

    // Bus conditions take precedence over any bit activity in the same
    // cycle; a coincident SCL rise sample is simply dropped.
    if (stop_cond) begin
      state_next     = ST_IDLE;
      drive_next     = 1'b0;
      match_next     = 1'b0;
      busy_next      = 1'b0;
      bit_cnt_next   = 4'd0;
      ack_phase_next = 1'b0;
      stop_next      = 1'b1;
    end else if (start_cond) begin
      state_next     = ST_ADDR;
      drive_next     = 1'b0;
      match_next     = 1'b0;
      busy_next      = 1'b1;
      bit_cnt_next   = 4'd0;
      shift_next     = 8'd0;
      ack_phase_next = 1'b0;
      start_next     = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_next = {shift_reg[6:0], sda_s};
            if (bit_cnt_inc == 4'd8) begin
              bit_cnt_next = 4'd0;
              rw_next      = sda_s;
              // shift_reg[6:0] already holds the 7 address bits here
              if (shift_reg[6:0] == DEVICE_ADDR) begin
                state_next = ST_ADDR_ACK;
              end else begin
                state_next = ST_WAIT_STOP;
              end
            end else begin
              bit_cnt_next = bit_cnt_inc;
            end
          end
        end

        ST_ADDR_ACK, ST_RX_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_reg) begin
              drive_next     = 1'b1;
              match_next     = 1'b1;
              ack_phase_next = 1'b1;
            end else begin
              ack_phase_next = 1'b0;
              drive_next     = 1'b0;
              if ((state_reg == ST_ADDR_ACK) && rw_reg) begin
                // Master read: present bit 7 in the same SCL low phase that
                // releases the ACK.
                shift_next   = tx_data;
                drive_next   = ~tx_data[7];
                tx_req_next  = 1'b1;
                bit_cnt_next = 4'd0;
                state_next   = ST_TX;
              end else begin
                if (state_reg == ST_ADDR_ACK) begin
                  first_pend_next = 1'b1;
                end
                bit_cnt_next = 4'd0;
                state_next   = ST_RX;
              end
            end
          end
        end

        ST_RX: begin
          if (scl_rise) begin
            shift_next = {shift_reg[6:0], sda_s};
            if (bit_cnt_inc == 4'd8) begin
              rx_byte_next    = {shift_reg[6:0], sda_s};
              rx_valid_next   = 1'b1;
              rx_first_next   = first_pend_reg;
              first_pend_next = 1'b0;
              bit_cnt_next    = 4'd0;
              state_next      = ST_RX_ACK;
            end else begin
              bit_cnt_next = bit_cnt_inc;
            end
          end
        end

        ST_TX: begin
          // Bit 7 is already on the bus when this state is entered; each SCL
          // fall moves on to the next bit, the 8th fall releases SDA.
          if (scl_fall) begin
            if (bit_cnt_inc == 4'd8) begin
              drive_next     = 1'b0;
              bit_cnt_next   = 4'd0;
              ack_phase_next = 1'b0;
              state_next     = ST_TX_ACK;
            end else begin
              shift_next   = {shift_reg[6:0], 1'b0};
              drive_next   = ~shift_reg[6];
              bit_cnt_next = bit_cnt_inc;
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_next = ST_WAIT_STOP;
            end else begin
              ack_phase_next = 1'b1;
            end
          end else if (scl_fall && ack_phase_reg) begin
            ack_phase_next = 1'b0;
            shift_next     = tx_data;
            drive_next     = ~tx_data[7];
            tx_req_next    = 1'b1;
            bit_cnt_next   = 4'd0;
            state_next     = ST_TX;
          end
        end

        ST_WAIT_STOP: begin
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= 8'd0;
      bit_cnt_reg    <= 4'd0;
      ack_phase_reg  <= 1'b0;
      first_pend_reg <= 1'b0;
      drive_reg      <= 1'b0;
      match_reg      <= 1'b0;
      rw_reg         <= 1'b0;
      rx_byte_reg    <= 8'd0;
      rx_valid_reg   <= 1'b0;
      rx_first_reg   <= 1'b0;
      tx_req_reg     <= 1'b0;
      start_reg      <= 1'b0;
      stop_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      ack_phase_reg  <= ack_phase_next;
      first_pend_reg <= first_pend_next;
      drive_reg      <= drive_next;
      match_reg      <= match_next;
      rw_reg         <= rw_next;
      rx_byte_reg    <= rx_byte_next;
      rx_valid_reg   <= rx_valid_next;
      rx_first_reg   <= rx_first_next;
      tx_req_reg     <= tx_req_next;
      start_reg      <= start_next;
      stop_reg       <= stop_next;
      busy_reg       <= busy_next;
    end
  end

  assign sda_drive_low = drive_reg;
  assign start_pulse   = start_reg;
  assign stop_pulse    = stop_reg;
  assign addr_match    = match_reg;
  assign rw_bit        = rw_reg;
  assign rx_byte       = rx_byte_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_first      = rx_first_reg;
  assign tx_req        = tx_req_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_i2c_slave_frontend.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_frontend
//
// Drives an I2C master bus model (wired-AND SDA) into i2c_slave_frontend.
// Expected received bytes and expected read-data bytes are pushed into
// queues when the stimulus is issued and popped when the DUT produces them.
// Build macro I2C_GLITCH_FILTER_EN enables the glitch-filter scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_frontend;

  localparam int SYNC_STAGES = 2;
`ifdef I2C_GLITCH_FILTER_EN
  localparam int RX_LAT = SYNC_STAGES + 3;
`else
  localparam int RX_LAT = SYNC_STAGES + 1;
`endif
  localparam int Q = 8;  // quarter SCL period in clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic [7:0] tx_data = 8'h00;

  logic       sda_drive_low;
  logic       start_pulse;
  logic       stop_pulse;
  logic       addr_match;
  logic       rw_bit;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_first;
  logic       tx_req;
  logic       busy;

  always #5 clock = ~clock;

  assign sda_bus = sda_m & ~sda_drive_low;

  i2c_slave_frontend #(
    .DEVICE_ADDR (7'h01),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .scl_in        (scl_m),
    .sda_in        (sda_bus),
    .sda_drive_low (sda_drive_low),
    .start_pulse   (start_pulse),
    .stop_pulse    (stop_pulse),
    .addr_match    (addr_match),
    .rw_bit        (rw_bit),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .rx_first      (rx_first),
    .tx_data       (tx_data),
    .tx_req        (tx_req),
    .busy          (busy)
  );

  int total = 0;
  int bad   = 0;

  int n_start = 0;
  int n_stop  = 0;
  int n_rx    = 0;
  int n_txreq = 0;
  int n_drive = 0;
  time last_rise = 0;

  logic [8:0] rx_exp_q[$];   // {first, byte}
  logic [7:0] tx_src_q[$];   // controller bytes still to hand over
  logic [7:0] tx_exp_q[$];   // bytes the master expects to read

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor and controller model; everything observed away from posedge.
  always @(negedge clock) begin
    if (start_pulse)   n_start++;
    if (stop_pulse)    n_stop++;
    if (sda_drive_low) n_drive++;
    if (tx_req) begin
      n_txreq++;
      if (tx_src_q.size() > 0) void'(tx_src_q.pop_front());
    end
    tx_data = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
    if (rx_valid) begin
      n_rx++;
      check_eq("rx_q_nonempty", (rx_exp_q.size() > 0), 1);
      if (rx_exp_q.size() > 0) begin
        logic [8:0] e;
        e = rx_exp_q.pop_front();
        check_eq("rx_byte", rx_byte, e[7:0]);
        check_eq("rx_first", rx_first, e[8]);
        check_eq("rx_latency", int'(($time - last_rise) / 10), RX_LAT);
        $display("rx byte=0x%02h first=%0b", rx_byte, rx_first);
      end
    end
  end

  // ---------------- master bus model ----------------
  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_rep_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; last_rise = $time; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic master_ack);
    logic [7:0] d;
    logic       b;
    logic [7:0] e;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~master_ack);
    check_eq("tx_q_nonempty", (tx_exp_q.size() > 0), 1);
    if (tx_exp_q.size() > 0) begin
      e = tx_exp_q.pop_front();
      check_eq("tx_byte", d, e);
    end
    $display("read byte=0x%02h master_ack=%0b", d, master_ack);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic ack;
    int b_start, b_stop, b_rx, b_tx, b_drive;

    // ---- reset state ----
    tick(4);
    check_eq("reset_drive", sda_drive_low, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_outs", {start_pulse, stop_pulse, addr_match, rw_bit, rx_valid, rx_first, tx_req, rx_byte}, 0);
    reset = 1'b0;
    tick(10);

    // ---- write: addr 0x02, word 0x15, data 0xA7 ----
    b_start = n_start; b_stop = n_stop; b_rx = n_rx;
    i2c_start();
    write_byte(8'h02, ack);
    check_eq("wr_addr_ack", ack, 0);
    check_eq("wr_match", addr_match, 1);
    check_eq("wr_rw", rw_bit, 0);
    check_eq("wr_busy", busy, 1);
    rx_exp_q.push_back({1'b1, 8'h15});
    write_byte(8'h15, ack);
    check_eq("wr_word_ack", ack, 0);
    rx_exp_q.push_back({1'b0, 8'hA7});
    write_byte(8'hA7, ack);
    check_eq("wr_data_ack", ack, 0);
    i2c_stop();
    tick(4);
    check_eq("wr_starts", n_start - b_start, 1);
    check_eq("wr_stops", n_stop - b_stop, 1);
    check_eq("wr_rx_count", n_rx - b_rx, 2);
    check_eq("wr_busy_end", busy, 0);
    check_eq("wr_match_end", addr_match, 0);
    $display("txn write addr=0x02 bytes=0x15,0xA7 done");

    // ---- address mismatch ----
    b_stop = n_stop; b_rx = n_rx; b_drive = n_drive;
    i2c_start();
    write_byte(8'h05, ack);
    check_eq("nm_addr_nack", ack, 1);
    write_byte(8'h77, ack);
    check_eq("nm_data_nack", ack, 1);
    check_eq("nm_match", addr_match, 0);
    i2c_stop();
    tick(4);
    check_eq("nm_drive_cycles", n_drive - b_drive, 0);
    check_eq("nm_rx_count", n_rx - b_rx, 0);
    check_eq("nm_stops", n_stop - b_stop, 1);
    check_eq("nm_busy_end", busy, 0);
    $display("txn nomatch addr=0x05 done");

    // ---- read: 0x3C with master ACK, 0xC3 with NACK ----
    b_tx = n_txreq;
    tx_src_q.push_back(8'h3C); tx_src_q.push_back(8'hC3);
    tx_exp_q.push_back(8'h3C); tx_exp_q.push_back(8'hC3);
    tick(2);
    i2c_start();
    write_byte(8'h03, ack);
    check_eq("rd_addr_ack", ack, 0);
    check_eq("rd_rw", rw_bit, 1);
    check_eq("rd_match", addr_match, 1);
    read_byte(1'b1);
    read_byte(1'b0);
    tick(4);
    check_eq("rd_txreq_count", n_txreq - b_tx, 2);
    check_eq("rd_wait_busy", busy, 1);
    check_eq("rd_wait_drive", sda_drive_low, 0);
    i2c_stop();
    tick(4);
    check_eq("rd_busy_end", busy, 0);
    $display("txn read addr=0x03 bytes=0x3C,0xC3 done");

    // ---- write word 0x10, repeated START, read ----
    b_start = n_start; b_tx = n_txreq;
    tx_src_q.push_back(8'h5A); tx_exp_q.push_back(8'h5A);
    tick(2);
    i2c_start();
    write_byte(8'h02, ack);
    check_eq("sr_wr_ack", ack, 0);
    rx_exp_q.push_back({1'b1, 8'h10});
    write_byte(8'h10, ack);
    check_eq("sr_word_ack", ack, 0);
    i2c_rep_start();
    check_eq("sr_match_cleared", addr_match, 0);
    write_byte(8'h03, ack);
    check_eq("sr_rd_ack", ack, 0);
    check_eq("sr_rw", rw_bit, 1);
    read_byte(1'b0);
    i2c_stop();
    tick(4);
    check_eq("sr_starts", n_start - b_start, 2);
    check_eq("sr_txreq_count", n_txreq - b_tx, 1);
    $display("txn repeated-start write 0x10 then read 0x5A done");

    // ---- STOP after 4 data bits ----
    b_stop = n_stop; b_rx = n_rx;
    i2c_start();
    write_byte(8'h02, ack);
    check_eq("ab_addr_ack", ack, 0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    check_eq("ab_busy", busy, 0);
    check_eq("ab_drive", sda_drive_low, 0);
    check_eq("ab_stops", n_stop - b_stop, 1);
    tick(4);
    check_eq("ab_rx_count", n_rx - b_rx, 0);
    $display("txn stop-abort after 4 bits done");

    // ---- reset while the slave drives read data ----
    tx_src_q.push_back(8'h00);
    tick(2);
    i2c_start();
    write_byte(8'h03, ack);
    check_eq("rs_addr_ack", ack, 0);
    check_eq("rs_drive_before", sda_drive_low, 1);
    reset = 1'b1;
    #1;
    check_eq("rs_drive_async", sda_drive_low, 0);
    check_eq("rs_busy_async", busy, 0);
    tick(2);
    reset = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1;
    tick(10);
    check_eq("rs_idle_busy", busy, 0);
    $display("txn reset during read drive done");

`ifdef I2C_GLITCH_FILTER_EN
    // ---- glitch filter ----
    b_start = n_start;
    sda_m = 1'b0; tick(2);
    sda_m = 1'b1; tick(10);
    check_eq("gf_short_start", n_start - b_start, 0);
    sda_m = 1'b0; tick(4);
    sda_m = 1'b1; tick(10);
    check_eq("gf_long_start", n_start - b_start, 1);
    $display("txn glitch filter 2-cycle and 4-cycle pulses done");
`endif

    check_eq("rx_q_drained", rx_exp_q.size(), 0);
    check_eq("tx_q_drained", tx_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
